// File: rtl/calc_entry_ctrl_if.sv
// ALU-side bundle of the calculator entry sequencer.
// master: sequencer (start, op, operands out; done, result in). slave: ALU.
interface calc_entry_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             alu_start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] num_a;
    logic [WIDTH-1:0] num_b;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output alu_start, alu_op, num_a, num_b,
        input  alu_done, alu_result
    );

    modport slave (
        input  alu_start, alu_op, num_a, num_b,
        output alu_done, alu_result
    );
endinterface

// File: rtl/calc_entry_ctrl.sv
// Calculator entry sequencer: key clicks -> operand A, operator, operand B,
// ALU start/done handshake, result latch and registered display select.
// Ports: clk, rst_n (sync, active-low), i_btnm, i_code, io_alu (master),
// o_result, o_disp_sel, o_disp_value, o_busy, o_err.
// Build option: CALC_TIMEOUT_EN adds an ALU watchdog of TIMEOUT_CYCLES.
module calc_entry_ctrl #(
    parameter int WIDTH          = 32,
    parameter int MAX_DIGITS     = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_btnm,
    input  logic [4:0]        i_code,
    calc_entry_ctrl_if.master io_alu,
    output logic [WIDTH-1:0]  o_result,
    output logic [1:0]        o_disp_sel,
    output logic [WIDTH-1:0]  o_disp_value,
    output logic              o_busy,
    output logic              o_err
);
    localparam logic [1:0] S_ENTER_A = 2'd0;
    localparam logic [1:0] S_ENTER_B = 2'd1;
    localparam logic [1:0] S_EXEC    = 2'd2;
    localparam logic [1:0] S_SHOW    = 2'd3;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [1:0]       r_state;
    logic             r_btnm_q;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_num_a;
    logic [WIDTH-1:0] r_num_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_disp_value;
    logic [2:0]       r_op;
    logic             r_start;
    logic             r_err;

`ifdef CALC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
`endif

    logic             w_ev;
    logic             w_is_dig;
    logic             w_is_op;
    logic             w_is_eq;
    logic             w_is_clr;
    logic             w_dig_ok;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_acc_a;
    logic [WIDTH-1:0] w_acc_b;
    logic [WIDTH-1:0] w_disp_next;
    logic [2:0]       w_op;

    // Rising edge of the button is the only key event.
    assign w_ev     = i_btnm & ~r_btnm_q;
    assign w_is_dig = w_ev && (i_code < 5'd10);
    assign w_is_op  = w_ev && (i_code >= 5'd10) && (i_code <= 5'd14);
    assign w_is_eq  = w_ev && (i_code == 5'd15);
    assign w_is_clr = w_ev && (i_code == 5'd16);
    assign w_dig_ok = (r_cnt < CNT_W'(MAX_DIGITS));
    assign w_d      = WIDTH'(i_code);
    assign w_op     = 3'(i_code - 5'd10);
    assign w_acc_a  = r_num_a * WIDTH'(10) + w_d;
    assign w_acc_b  = r_num_b * WIDTH'(10) + w_d;

    always_comb begin
        o_disp_sel = 2'd0;
        case (r_state)
            S_ENTER_B: o_disp_sel = 2'd1;
            S_EXEC:    o_disp_sel = 2'd1;
            S_SHOW:    o_disp_sel = 2'd2;
            default:   o_disp_sel = 2'd0;
        endcase
    end

    always_comb begin
        w_disp_next = r_num_a;
        case (o_disp_sel)
            2'd1:    w_disp_next = r_num_b;
            2'd2:    w_disp_next = r_result;
            default: w_disp_next = r_num_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_ENTER_A;
            r_btnm_q     <= 1'b0;
            r_cnt        <= '0;
            r_num_a      <= '0;
            r_num_b      <= '0;
            r_result     <= '0;
            r_disp_value <= '0;
            r_op         <= 3'd0;
            r_start      <= 1'b0;
            r_err        <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            r_tmo        <= '0;
`endif
        end else begin
            r_btnm_q     <= i_btnm;
            r_start      <= 1'b0;
            r_disp_value <= w_disp_next;
            if (w_is_clr) begin
                // Clear wins over everything, including a same-cycle done.
                r_state  <= S_ENTER_A;
                r_cnt    <= '0;
                r_num_a  <= '0;
                r_num_b  <= '0;
                r_result <= '0;
                r_op     <= 3'd0;
                r_err    <= 1'b0;
            end else begin
                case (r_state)
                    S_ENTER_A: begin
                        if (w_is_dig && w_dig_ok) begin
                            r_num_a <= w_acc_a;
                            r_cnt   <= r_cnt + 1'b1;
                        end else if (w_is_op) begin
                            r_op    <= w_op;
                            r_cnt   <= '0;
                            r_num_b <= '0;
                            r_state <= S_ENTER_B;
                        end
                    end
                    S_ENTER_B: begin
                        if (w_is_dig && w_dig_ok) begin
                            r_num_b <= w_acc_b;
                            r_cnt   <= r_cnt + 1'b1;
                        end else if (w_is_op && (r_cnt == '0)) begin
                            r_op    <= w_op;
                        end else if (w_is_eq) begin
                            // start is registered so it lands in the
                            // first EXEC cycle.
                            r_start <= 1'b1;
                            r_state <= S_EXEC;
`ifdef CALC_TIMEOUT_EN
                            r_tmo   <= '0;
`endif
                        end
                    end
                    S_EXEC: begin
                        if (io_alu.alu_done) begin
                            r_result <= io_alu.alu_result;
                            r_state  <= S_SHOW;
                        end
`ifdef CALC_TIMEOUT_EN
                        else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_state  <= S_SHOW;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
`endif
                    end
                    default: begin
                        if (w_is_dig) begin
                            r_num_a <= w_d;
                            r_cnt   <= CNT_W'(1);
                            r_num_b <= '0;
                            r_state <= S_ENTER_A;
                        end else if (w_is_op) begin
                            // Chain: previous result becomes operand A.
                            r_num_a <= r_result;
                            r_op    <= w_op;
                            r_num_b <= '0;
                            r_cnt   <= '0;
                            r_state <= S_ENTER_B;
                        end
                    end
                endcase
            end
        end
    end

    assign io_alu.alu_start = r_start;
    assign io_alu.alu_op    = r_op;
    assign io_alu.num_a     = r_num_a;
    assign io_alu.num_b     = r_num_b;
    assign o_result         = r_result;
    assign o_disp_value     = r_disp_value;
    assign o_busy           = (r_state == S_EXEC);
    assign o_err            = r_err;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: key-press vector table plus
// hand-written ALU handshake, clear-abort, hold and reset sequences.
module tb_calc_entry_ctrl;
    logic        clk;
    logic        rst_n;
    logic        btnm;
    logic [4:0]  code;
    logic [31:0] result;
    logic [1:0]  disp_sel;
    logic [31:0] disp_value;
    logic        busy;
    logic        err;

    int total;
    int bad;
    int n_start;
    int exp_start;

    calc_entry_ctrl_if #(.WIDTH(32)) ifc ();

    calc_entry_ctrl #(
        .WIDTH(32),
        .MAX_DIGITS(9),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_btnm(btnm),
        .i_code(code),
        .io_alu(ifc),
        .o_result(result),
        .o_disp_sel(disp_sel),
        .o_disp_value(disp_value),
        .o_busy(busy),
        .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ifc.alu_start === 1'b1) n_start++;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [1:0]  sel;
        logic [31:0] disp;
    } vec_t;

    vec_t vt[0:31];
    int   nv;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic [1:0] sel, input logic [31:0] disp);
        vt[nv] = '{c, a, b, op, sel, disp};
        nv++;
    endtask

    // Called and returns at a negedge.
    task automatic press(input logic [4:0] c);
        code = c;
        btnm = 1'b1;
        @(negedge clk);
        btnm = 1'b0;
        code = 5'd31;
        @(negedge clk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            press(vt[i].code);
            chk($sformatf("v%0d num_a", i), ifc.num_a, vt[i].a);
            chk($sformatf("v%0d num_b", i), ifc.num_b, vt[i].b);
            chk($sformatf("v%0d alu_op", i), 32'(ifc.alu_op), 32'(vt[i].op));
            chk($sformatf("v%0d disp_sel", i), 32'(disp_sel), 32'(vt[i].sel));
            chk($sformatf("v%0d disp_value", i), disp_value, vt[i].disp);
        end
    endtask

    // Equals, then ALU answers lat cycles after the first EXEC cycle.
    task automatic do_exec(input int lat, input logic [31:0] res);
        code = 5'd15;
        btnm = 1'b1;
        @(negedge clk);
        btnm = 1'b0;
        code = 5'd31;
        exp_start++;
        chk("exec busy", 32'(busy), 32'd1);
        chk("exec start", 32'(ifc.alu_start), 32'd1);
        if (lat > 0) repeat (lat) @(negedge clk);
        ifc.alu_done   = 1'b1;
        ifc.alu_result = res;
        @(negedge clk);
        ifc.alu_done   = 1'b0;
        ifc.alu_result = 32'd0;
        @(negedge clk);
        chk("exec result", result, res);
        chk("exec sel", 32'(disp_sel), 32'd2);
        chk("exec disp", disp_value, res);
        chk("exec busy end", 32'(busy), 32'd0);
        chk("exec starts", 32'(n_start), 32'(exp_start));
    endtask

    int s0, s1, s2;

    initial begin
        total = 0; bad = 0; n_start = 0; exp_start = 0; nv = 0;

        add(5'd15, 0, 0, 0, 0, 0);
        add(5'd1, 1, 0, 0, 0, 1);
        add(5'd20, 1, 0, 0, 0, 1);
        add(5'd2, 12, 0, 0, 0, 12);
        add(5'd3, 123, 0, 0, 0, 123);
        add(5'd10, 123, 0, 0, 1, 0);
        add(5'd4, 123, 4, 0, 1, 4);
        add(5'd5, 123, 45, 0, 1, 45);
        s0 = nv;
        add(5'd15, 123, 45, 0, 2, 168);
        add(5'd12, 168, 0, 2, 1, 0);
        add(5'd14, 168, 0, 4, 1, 0);
        add(5'd12, 168, 0, 2, 1, 0);
        add(5'd2, 168, 2, 2, 1, 2);
        add(5'd13, 168, 2, 2, 1, 2);
        s1 = nv;
        add(5'd16, 0, 0, 0, 0, 0);
        add(5'd9, 9, 0, 0, 0, 9);
        add(5'd9, 99, 0, 0, 0, 99);
        add(5'd9, 999, 0, 0, 0, 999);
        add(5'd9, 9999, 0, 0, 0, 9999);
        add(5'd9, 99999, 0, 0, 0, 99999);
        add(5'd9, 999999, 0, 0, 0, 999999);
        add(5'd9, 9999999, 0, 0, 0, 9999999);
        add(5'd9, 99999999, 0, 0, 0, 99999999);
        add(5'd9, 999999999, 0, 0, 0, 999999999);
        add(5'd9, 999999999, 0, 0, 0, 999999999);
        s2 = nv;

        rst_n = 1'b0;
        btnm = 1'b0;
        code = 5'd31;
        ifc.alu_done = 1'b0;
        ifc.alu_result = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst num_a", ifc.num_a, 0);
        chk("rst num_b", ifc.num_b, 0);
        chk("rst result", result, 0);
        chk("rst op", 32'(ifc.alu_op), 0);
        chk("rst sel", 32'(disp_sel), 0);
        chk("rst disp", disp_value, 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst err", 32'(err), 0);
        @(negedge clk);
        chk("rst start", 32'(n_start), 0);

        run_vecs(0, s0);
        do_exec(3, 32'd168);
        run_vecs(s0, s1);
        do_exec(0, 32'd170);
        run_vecs(s1, s2);

        press(5'd16);
        code = 5'd7;
        btnm = 1'b1;
        repeat (20) @(negedge clk);
        btnm = 1'b0;
        code = 5'd31;
        @(negedge clk);
        chk("hold num_a", ifc.num_a, 7);
        chk("hold disp", disp_value, 7);

        press(5'd10);
        press(5'd3);
        do_exec(1, 32'd10);
        press(5'd7);
        chk("show dig a", ifc.num_a, 7);
        chk("show dig b", ifc.num_b, 0);
        chk("show dig sel", 32'(disp_sel), 0);
        for (int i = 0; i < 9; i++) press(5'd1);
        chk("show dig cnt", ifc.num_a, 711111111);

        press(5'd10);
        press(5'd5);
        code = 5'd15;
        btnm = 1'b1;
        @(negedge clk);
        btnm = 1'b0;
        code = 5'd31;
        exp_start++;
        chk("abort busy", 32'(busy), 1);
        @(negedge clk);
        press(5'd16);
        ifc.alu_done = 1'b1;
        ifc.alu_result = 32'd555;
        @(negedge clk);
        ifc.alu_done = 1'b0;
        @(negedge clk);
        chk("abort result", result, 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort sel", 32'(disp_sel), 0);
        chk("abort num_a", ifc.num_a, 0);
        chk("abort err", 32'(err), 0);

`ifdef CALC_TIMEOUT_EN
        press(5'd10);
        code = 5'd15;
        btnm = 1'b1;
        @(negedge clk);
        btnm = 1'b0;
        code = 5'd31;
        exp_start++;
        repeat (15) @(negedge clk);
        chk("tmo busy16", 32'(busy), 1);
        @(negedge clk);
        chk("tmo busy", 32'(busy), 0);
        chk("tmo err", 32'(err), 1);
        chk("tmo sel", 32'(disp_sel), 2);
        chk("tmo result", result, 0);
        ifc.alu_done = 1'b1;
        ifc.alu_result = 32'd99;
        @(negedge clk);
        ifc.alu_done = 1'b0;
        @(negedge clk);
        chk("tmo stray", result, 0);
        press(5'd16);
        chk("tmo clr err", 32'(err), 0);
`endif

        press(5'd10);
        code = 5'd15;
        btnm = 1'b1;
        @(negedge clk);
        btnm = 1'b0;
        code = 5'd31;
        exp_start++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst sel", 32'(disp_sel), 0);
        chk("starts total", 32'(n_start), 32'(exp_start));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Clocked sequencer for the calculator datapath: converts mouse-click key codes into operand A, operator and operand B.
- Launches the ALU with a start/done handshake, latches the result and selects which value is sent to the display formatter.
- Sits between the mouse/keypad hit decoder (code, btnm) and the ALU plus the display number stage.

Parameters:
- WIDTH, 32, operand/result width in bits.
- MAX_DIGITS, 9, maximum decimal digits accepted per operand.
- TIMEOUT_CYCLES, 1024, ALU watchdog limit in clk cycles; used only with CALC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- btnm  in  1  mouse left button level, already synchronous to clk.
- code  in  5  key code under cursor: 0-9 digit, 10-14 operator, 15 equals, 16 clear, 17-31 no key.
- alu_done  in  1  one-cycle pulse, ALU result valid.
- alu_result  in  WIDTH  ALU result, sampled when alu_done=1.
- alu_start  out  1  one-cycle pulse that launches the ALU.
- alu_op  out  3  latched operator, code-10 (0-4).
- num_a  out  WIDTH  operand A register.
- num_b  out  WIDTH  operand B register.
- result  out  WIDTH  latched result register.
- disp_sel  out  2  0=A, 1=B, 2=result.
- disp_value  out  WIDTH  registered mux of num_a/num_b/result per disp_sel.
- busy  out  1  high in EXEC.
- err  out  1  sticky error; cleared by clear key or reset.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=ENTER_A; all registers and outputs 0; digit counter 0; btnm_q=0.
- Key event: ev = btnm & ~btnm_q, with btnm_q registered every cycle. One event per press; holding the button yields no repeats. code is sampled in the ev cycle.
- Digit d: acc = acc*10 + d, truncated to WIDTH. Accepted only while the digit count < MAX_DIGITS; otherwise ignored. Each accepted digit increments the count.
- States and transitions:
  - ENTER_A, disp_sel=0:
    - digit: updates num_a.
    - operator: alu_op=code-10, count=0, num_b=0, go to ENTER_B (allowed with zero digits, so A=0).
    - equals: ignored.
  - ENTER_B, disp_sel=1:
    - digit: updates num_b.
    - operator with zero B digits: replaces alu_op.
    - operator with B digits already entered: ignored.
    - equals: go to EXEC.
  - EXEC, disp_sel=1, busy=1:
    - alu_start=1 exactly in the first EXEC cycle.
    - Waits for alu_done, then result<=alu_result and go to SHOW_RES.
    - All key events except clear are ignored.
  - SHOW_RES, disp_sel=2:
    - digit: num_a=d, count=1, num_b=0, go to ENTER_A.
    - operator: num_a=result, alu_op=code-10, num_b=0, count=0, go to ENTER_B (chaining).
    - equals: ignored.
- Clear (16): from any state, on the next edge num_a, num_b, result, alu_op, count and err go to 0 and state goes to ENTER_A. In EXEC this aborts the operation; an alu_done arriving later is ignored.
- alu_done outside EXEC is ignored. alu_done in the same cycle as alu_start is accepted.
- Codes 17-31 are ignored in every state.
- disp_value updates one cycle after any change of its source register or of disp_sel.
- Reset mid-operation behaves as reset; alu_start is never asserted in the cycle after reset.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- Defined:
  - A counter clears on EXEC entry and increments each EXEC cycle.
  - If it reaches TIMEOUT_CYCLES without alu_done: result=0, err=1, go to SHOW_RES.
  - A later stray alu_done is ignored.
- Not defined: no counter; EXEC waits indefinitely for alu_done or clear; err stays 0.

Test Plan:
- Reset, then press codes 1,2,3, then 10 (op0), 4,5, then 15; ALU returns 168 after 3 cycles -> num_a=123, alu_op=0, num_b=45, one alu_start pulse, result=168, disp_sel=2.
- Hold btnm high for 20 cycles with code=7 in ENTER_A -> num_a=7 (single event).
- Press 10 digits of 9 -> num_a=999999999; the 10th digit is ignored.
- In SHOW_RES with result=168, press 12 then 2 then 15 -> num_a=168, alu_op=2, num_b=2, a new alu_start.
- Press 16 during EXEC, then pulse alu_done with 555 -> state ENTER_A, result=0, 555 never latched.
- With CALC_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold alu_done -> after 16 EXEC cycles err=1, result=0, disp_sel=2; a following press of 16 clears err.
